seg7_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a bank of common-anode 7-segment digits that share one hex-to-segment decoder. Each cycle it selects one nibble of a double-buffered display value, drives the decoder's data and enable inputs, and strobes the matching active-low digit select. An anti-ghosting blank gap is inserted between digits. Sits between the display-value producer (counter, FSM, etc.) and the shared decoder / board anode pins.

---
 rtl/seg7_scan_ctrl.sv | 108 ++++++++++
 tb/tb_seg7_scan_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed 7-segment scan controller with a double-buffered value and blank gaps between digits.
// Define SEG7_LZS_EN to enable leading-zero suppression.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic [4*NUM_DIGITS-1:0] VALUE,
    input  logic                    LOAD,
    input  logic [NUM_DIGITS-1:0]   DIGIT_EN,
    output logic [3:0]              DEC_DIN,
    output logic                    DEC_EN,
    output logic [NUM_DIGITS-1:0]   DIGIT_SEL,
    output logic                    FRAME_DONE
);
    localparam int CW = $clog2(CLK_DIV);
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic {S_BLANK, S_DRIVE} state_t;
    localparam state_t S_START = BLANK_CYCLES > 0 ? S_BLANK : S_DRIVE;

    state_t                  r_state, w_state_nxt;
    logic [CW-1:0]           r_cnt, w_cnt_nxt;
    logic [IW-1:0]           r_idx, w_idx_nxt;
    logic [4*NUM_DIGITS-1:0] r_active, r_pending;
    logic                    r_pend;
    logic                    w_wrap, w_bound, w_on, w_en_nxt;
    logic [3:0]              w_nib, w_din_nxt;
    logic [NUM_DIGITS-1:0]   w_sel_nxt;

    assign w_wrap      = r_cnt == CW'(CLK_DIV - 1);
    assign w_bound     = w_wrap && r_idx == IW'(NUM_DIGITS - 1);
    assign w_cnt_nxt   = w_wrap ? '0 : r_cnt + 1'b1;
    assign w_idx_nxt   = w_bound ? '0 : w_wrap ? r_idx + 1'b1 : r_idx;
    assign w_state_nxt = int'(w_cnt_nxt) < BLANK_CYCLES ? S_BLANK : S_DRIVE;
    assign w_nib       = r_active[{r_idx, 2'b00} +: 4];

`ifdef SEG7_LZS_EN
    // A digit is suppressed when it and every more-significant active nibble are zero.
    logic [NUM_DIGITS-1:0] w_sup;
    always_comb begin
        logic w_z;
        w_z = 1'b1;
        w_sup = '0;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            w_z = w_z && r_active[4*k +: 4] == 4'd0;
            w_sup[k] = w_z;
        end
    end
    assign w_on = DIGIT_EN[r_idx] && !w_sup[r_idx];
`else
    assign w_on = DIGIT_EN[r_idx];
`endif

    always_comb begin
        w_sel_nxt = '1;
        w_en_nxt  = 1'b0;
        w_din_nxt = DEC_DIN;
        if (r_state == S_DRIVE) begin
            w_din_nxt = w_nib;
            w_en_nxt  = w_on;
            w_sel_nxt = w_on ? ~(NUM_DIGITS'(1) << r_idx) : '1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= S_START;
            r_cnt      <= '0;
            r_idx      <= '0;
            DIGIT_SEL  <= '1;
            DEC_EN     <= 1'b0;
            DEC_DIN    <= 4'd0;
            FRAME_DONE <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_idx      <= w_idx_nxt;
            DIGIT_SEL  <= w_sel_nxt;
            DEC_EN     <= w_en_nxt;
            DEC_DIN    <= w_din_nxt;
            FRAME_DONE <= w_bound;
        end
    end

    // New values only reach the active buffer at a frame boundary, so a frame never mixes values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_active  <= '0;
            r_pending <= '0;
            r_pend    <= 1'b0;
        end else begin
            if (LOAD)
                r_pending <= VALUE;
            if (w_bound) begin
                r_pend <= 1'b0;
                if (LOAD)
                    r_active <= VALUE;
                else if (r_pend)
                    r_active <= r_pending;
            end else if (LOAD) begin
                r_pend <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed, table-driven bench for seg7_scan_ctrl (N=4, CLK_DIV=8, BLANK=2).
// Honours SEG7_LZS_EN when defined for the leading-zero checks.
module tb_seg7_scan_ctrl;
`ifdef SEG7_LZS_EN
    localparam bit LZS = 1'b1;
`else
    localparam bit LZS = 1'b0;
`endif

    logic        CLK, RST_N, LOAD, DEC_EN, FRAME_DONE;
    logic [15:0] VALUE;
    logic [3:0]  DIGIT_EN, DEC_DIN, DIGIT_SEL;
    int          e, errors, checks;

    seg7_scan_ctrl #(.NUM_DIGITS(4), .CLK_DIV(8), .BLANK_CYCLES(2)) dut (
        .CLK(CLK), .RST_N(RST_N), .VALUE(VALUE), .LOAD(LOAD), .DIGIT_EN(DIGIT_EN),
        .DEC_DIN(DEC_DIN), .DEC_EN(DEC_EN), .DIGIT_SEL(DIGIT_SEL), .FRAME_DONE(FRAME_DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Cycle index since reset release; outputs at e reflect slot state (e-1).
    always @(posedge CLK or negedge RST_N)
        if (!RST_N) e <= 0;
        else e <= e + 1;

    typedef struct {
        int         fr, di, c;
        logic [3:0] den;
        logic       ld;
        logic [15:0] val;
        logic [3:0] sel;
        logic       en;
        logic       chk_din;
        logic [3:0] din;
    } vec_t;
    vec_t tbl[18];

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string n, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at e=%0d: got %h expected %h", n, e, got, exp);
        end
    endtask

    task automatic goto(input int t);
        if (e > t) begin
            errors++;
            $display("FAIL goto: at e=%0d expected to reach %0d", e, t);
        end
        while (e < t) step();
    endtask

    task automatic chk_out(input string n, input logic [3:0] sel, input logic en, input logic cd, input logic [3:0] din);
        chk({n, ".sel"}, 8'(DIGIT_SEL), 8'(sel));
        chk({n, ".en"}, 8'(DEC_EN), 8'(en));
        if (cd) chk({n, ".din"}, 8'(DEC_DIN), 8'(din));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        errors = 0; checks = 0;
        //          fr di c  den   ld val       sel   en chk din
        tbl[0]  = '{1, 0, 0, 4'hF, 0, 16'h0,    4'hF, 0, 1, 4'h0};
        tbl[1]  = '{1, 0, 2, 4'hF, 0, 16'h0,    4'hE, 1, 1, 4'h4};
        tbl[2]  = '{1, 0, 7, 4'hF, 0, 16'h0,    4'hE, 1, 1, 4'h4};
        tbl[3]  = '{1, 1, 0, 4'hF, 0, 16'h0,    4'hF, 0, 1, 4'h4};
        tbl[4]  = '{1, 1, 2, 4'hF, 1, 16'hABCD, 4'hD, 1, 1, 4'h3};
        tbl[5]  = '{1, 2, 1, 4'hF, 0, 16'h0,    4'hF, 0, 1, 4'h3};
        tbl[6]  = '{1, 2, 4, 4'hF, 0, 16'h0,    4'hB, 1, 1, 4'h2};
        tbl[7]  = '{1, 3, 3, 4'hF, 0, 16'h0,    4'h7, 1, 1, 4'h1};
        tbl[8]  = '{2, 0, 3, 4'hF, 0, 16'h0,    4'hE, 1, 1, 4'hD};
        tbl[9]  = '{2, 1, 3, 4'hF, 0, 16'h0,    4'hD, 1, 1, 4'hC};
        tbl[10] = '{2, 2, 3, 4'hA, 0, 16'h0,    4'hF, 0, 0, 4'h0};
        tbl[11] = '{2, 3, 3, 4'hA, 0, 16'h0,    4'h7, 1, 1, 4'hA};
        tbl[12] = '{3, 0, 4, 4'hA, 0, 16'h0,    4'hF, 0, 0, 4'h0};
        tbl[13] = '{3, 1, 4, 4'hA, 0, 16'h0,    4'hD, 1, 1, 4'hC};
        tbl[14] = '{3, 2, 3, 4'hA, 0, 16'h0,    4'hF, 0, 0, 4'h0};
        tbl[15] = '{3, 2, 4, 4'hA, 0, 16'h0,    4'hF, 0, 0, 4'h0};
        tbl[16] = '{3, 2, 5, 4'hF, 0, 16'h0,    4'hB, 1, 1, 4'hB};
        tbl[17] = '{3, 3, 2, 4'hF, 0, 16'h0,    4'h7, 1, 1, 4'hA};

        RST_N = 1'b0; LOAD = 1'b0; VALUE = 16'h0; DIGIT_EN = 4'hF;
        repeat (3) step();
        chk_out("reset", 4'hF, 1'b0, 1'b1, 4'h0);
        chk("reset.fd", 8'(FRAME_DONE), 8'h0);
        RST_N = 1'b1;
        goto(1);
        chk_out("first_blank", 4'hF, 1'b0, 1'b1, 4'h0);
        goto(3);
        chk_out("first_drive", 4'hE, 1'b1, 1'b1, 4'h0);
        VALUE = 16'h1234; LOAD = 1'b1;
        step();
        LOAD = 1'b0;
        goto(11);
        chk_out("pending_not_shown", 4'hD, 1'b1, 1'b1, 4'h0);
        goto(31);
        chk("fd_before", 8'(FRAME_DONE), 8'h0);
        step();
        chk("fd_pulse", 8'(FRAME_DONE), 8'h1);

        foreach (tbl[i]) begin
            goto(tbl[i].fr * 32 + tbl[i].di * 8 + tbl[i].c);
            DIGIT_EN = tbl[i].den;
            if (tbl[i].ld) begin
                VALUE = tbl[i].val;
                LOAD = 1'b1;
            end
            step();
            LOAD = 1'b0;
            chk_out($sformatf("vec%0d", i), tbl[i].sel, tbl[i].en, tbl[i].chk_din, tbl[i].din);
            if (i == 0) chk("fd_one_cycle", 8'(FRAME_DONE), 8'h0);
        end

        goto(127);
        chk("fd_f3_before", 8'(FRAME_DONE), 8'h0);
        chk_out("f3_last", 4'h7, 1'b1, 1'b1, 4'hA);
        VALUE = 16'h5678; LOAD = 1'b1;
        step();
        LOAD = 1'b0;
        chk("fd_f3", 8'(FRAME_DONE), 8'h1);
        chk_out("f3_end", 4'h7, 1'b1, 1'b1, 4'hA);
        goto(131);
        chk_out("boundary_load_d0", 4'hE, 1'b1, 1'b1, 4'h8);
        goto(155);
        chk_out("boundary_load_d3", 4'h7, 1'b1, 1'b1, 4'h5);

        goto(181);
        chk_out("pre_reset_d2", 4'hB, 1'b1, 1'b1, 4'h6);
        #2 RST_N = 1'b0;
        #1;
        chk_out("async_reset", 4'hF, 1'b0, 1'b1, 4'h0);
        chk("async_reset.fd", 8'(FRAME_DONE), 8'h0);
        step();
        step();
        RST_N = 1'b1;
        goto(1);
        chk_out("restart_blank", 4'hF, 1'b0, 1'b1, 4'h0);
        goto(3);
        chk_out("restart_d0", 4'hE, 1'b1, 1'b1, 4'h0);

        VALUE = 16'h0050; LOAD = 1'b1;
        step();
        LOAD = 1'b0;
        goto(35);
        chk_out("lz_d0", 4'hE, 1'b1, 1'b1, 4'h0);
        goto(43);
        chk_out("lz_d1", 4'hD, 1'b1, 1'b1, 4'h5);
        goto(51);
        chk_out("lz_d2", LZS ? 4'hF : 4'hB, !LZS, !LZS, 4'h0);
        goto(59);
        chk_out("lz_d3", LZS ? 4'hF : 4'h7, !LZS, !LZS, 4'h0);
        VALUE = 16'h0000; LOAD = 1'b1;
        step();
        LOAD = 1'b0;
        goto(64);
        chk("fd_f1_restart", 8'(FRAME_DONE), 8'h1);
        goto(67);
        chk_out("zero_d0", 4'hE, 1'b1, 1'b1, 4'h0);
        goto(75);
        chk_out("zero_d1", LZS ? 4'hF : 4'hD, !LZS, !LZS, 4'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
